// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_param_pkg: read-mode constants and depth helper shared by the FIFO files
package sync_fifo_param_pkg;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: FIFO bus (clr, din/we, re, dout/valid, status flags, count, error flags); master drives requests, slave is the FIFO
interface sync_fifo_param_if #(
  parameter int DWIDTH = 60,
  parameter int AWIDTH = 9
);
  logic clr;
  logic [DWIDTH-1:0] din;
  logic we;
  logic re;
  logic [DWIDTH-1:0] dout;
  logic valid;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [AWIDTH:0] count;
  logic overflow;
  logic underflow;
  modport master (
    output clr, din, we, re,
    input dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input clr, din, we, re,
    output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_sdpram.sv
// sdpram_param: simple dual-port RAM (clk; we/waddr/wdata write port; re/raddr/rdata registered read port, old data on collision)
module sdpram_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DWIDTH = 60,
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
`ifdef hard_mem
  dual_port_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .din(wdata),
    .re(re), .raddr(raddr), .dout(rdata)
  );
`else
  logic [DWIDTH-1:0] mem [depth_of(AWIDTH)];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
`endif
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised sync FIFO (clk, rst, slave bus f) with standard/FWFT read, count, almost flags, sticky errors
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DWIDTH = 60,
  parameter int AWIDTH = 9,
  parameter int FWFT = FIFO_STD,
  parameter int AFULL_TH = depth_of(AWIDTH) - 4,
  parameter int AEMPTY_TH = 4
) (
  input logic clk,
  input logic rst,
  sync_fifo_param_if.slave f
);
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(depth_of(AWIDTH));
  localparam logic [AWIDTH:0] AF_W = (AWIDTH+1)'(AFULL_TH);
  localparam logic [AWIDTH:0] AE_W = (AWIDTH+1)'(AEMPTY_TH);
  localparam logic [AWIDTH:0] ONE = (AWIDTH+1)'(1);
  logic [AWIDTH:0] wp, rp, ram_words, cnt;
  logic valid_r, valid_nxt, dout_zero, ovf, unf;
  logic full_w, empty_w, wr_ok, rd_ok, ram_re;
  logic [DWIDTH-1:0] rdata;
  assign ram_words = wp - rp;
  assign full_w = cnt == DEPTH_W;
  assign wr_ok = f.we && !full_w && !f.clr;
  assign rd_ok = f.re && !empty_w && !f.clr;
  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // the output register holds the head word, so it counts as stored
      assign cnt = ram_words + (AWIDTH+1)'(valid_r);
      assign empty_w = !valid_r;
      assign ram_re = (!valid_r || rd_ok) && ram_words != '0 && !f.clr;
      assign valid_nxt = ram_re || (valid_r && !rd_ok);
    end else begin : g_std
      assign cnt = ram_words;
      assign empty_w = cnt == '0;
      assign ram_re = rd_ok;
      assign valid_nxt = rd_ok;
    end
  endgenerate
  sdpram_param #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
    .clk(clk), .we(wr_ok), .waddr(wp[AWIDTH-1:0]), .wdata(f.din),
    .re(ram_re), .raddr(rp[AWIDTH-1:0]), .rdata(rdata)
  );
  // the RAM read register cannot be reset, so dout is forced to zero until the first read after a flush
  always_ff @(posedge clk) begin
    if (rst || f.clr) begin
      wp <= '0;
      rp <= '0;
      valid_r <= 1'b0;
      dout_zero <= 1'b1;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + ONE;
      if (ram_re) rp <= rp + ONE;
      if (ram_re) dout_zero <= 1'b0;
      valid_r <= valid_nxt;
      ovf <= ovf | (f.we && full_w);
      unf <= unf | (f.re && empty_w);
    end
  end
  assign f.dout = dout_zero ? '0 : rdata;
  assign f.valid = valid_r;
  assign f.full = full_w;
  assign f.empty = empty_w;
  assign f.almost_full = cnt >= AF_W;
  assign f.almost_empty = cnt <= AE_W;
  assign f.count = cnt;
  assign f.overflow = ovf;
  assign f.underflow = unf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: standard and FWFT FIFOs driven in lockstep, checked against queue models and literal expectations
module tb_sync_fifo_param;
  import sync_fifo_param_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [7:0] din = '0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  sync_fifo_param_if #(.DWIDTH(8), .AWIDTH(2)) ia ();
  sync_fifo_param_if #(.DWIDTH(8), .AWIDTH(2)) ib ();
  assign ia.we = we;
  assign ia.re = re;
  assign ia.din = din;
  assign ia.clr = clr;
  assign ib.we = we;
  assign ib.re = re;
  assign ib.din = din;
  assign ib.clr = clr;
  sync_fifo_param #(.DWIDTH(8), .AWIDTH(2), .FWFT(FIFO_STD), .AFULL_TH(3), .AEMPTY_TH(1))
    dut_a (.clk(clk), .rst(rst), .f(ia));
  sync_fifo_param #(.DWIDTH(8), .AWIDTH(2), .FWFT(FIFO_FWFT), .AFULL_TH(3), .AEMPTY_TH(1))
    dut_b (.clk(clk), .rst(rst), .f(ib));
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  logic [7:0] qa[$], qb[$];
  logic [7:0] da = '0, db = '0;
  logic va = 1'b0, hv = 1'b0, ova = 1'b0, una = 1'b0, ovb = 1'b0, unb = 1'b0;
  always @(posedge clk) begin
    if (rst || clr) begin
      qa.delete();
      qb.delete();
      da = '0;
      db = '0;
      va = 1'b0;
      hv = 1'b0;
      ova = 1'b0;
      una = 1'b0;
      ovb = 1'b0;
      unb = 1'b0;
    end else begin
      automatic bit fa = qa.size() == 4, ea = qa.size() == 0;
      automatic bit fb = qb.size() == 4, eb = !hv;
      automatic int rw = qb.size() - int'(hv);
      automatic bit rdb = re && hv;
      ova |= we && fa;
      una |= re && ea;
      va = re && !ea;
      if (re && !ea) da = qa.pop_front();
      if (we && !fa) qa.push_back(din);
      ovb |= we && fb;
      unb |= re && eb;
      if (rdb) void'(qb.pop_front());
      hv = (hv && !rdb) ? 1'b1 : (rw > 0);
      if (we && !fb) qb.push_back(din);
      if (hv) db = qb[0];
    end
  end
  always @(negedge clk) begin
    chk("a_dout", ia.dout, da);
    chk("a_valid", ia.valid, va);
    chk("a_count", ia.count, qa.size());
    chk("a_full", ia.full, qa.size() == 4);
    chk("a_empty", ia.empty, qa.size() == 0);
    chk("a_afull", ia.almost_full, qa.size() >= 3);
    chk("a_aempty", ia.almost_empty, qa.size() <= 1);
    chk("a_ovf", ia.overflow, ova);
    chk("a_unf", ia.underflow, una);
    chk("b_dout", ib.dout, db);
    chk("b_valid", ib.valid, hv);
    chk("b_count", ib.count, qb.size());
    chk("b_full", ib.full, qb.size() == 4);
    chk("b_empty", ib.empty, !hv);
    chk("b_afull", ib.almost_full, qb.size() >= 3);
    chk("b_aempty", ib.almost_empty, qb.size() <= 1);
    chk("b_ovf", ib.overflow, ovb);
    chk("b_unf", ib.underflow, unb);
  end
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    we = w;
    re = r;
    din = d;
    clr = c;
    @(negedge clk);
    we = 1'b0;
    re = 1'b0;
    clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", ia.dout, 8'h00);
    chk("rst_valid", ia.valid, 0);
    chk("rst_count", ia.count, 0);
    chk("rst_empty", ia.empty, 1);
    chk("rst_full", ia.full, 0);
    chk("rst_aempty", ia.almost_empty, 1);
    chk("rst_afull", ia.almost_full, 0);
    chk("rst_b_empty", ib.empty, 1);
    cyc(1, 0, 8'h11, 0);
    cyc(1, 0, 8'h22, 0);
    cyc(1, 0, 8'h33, 0);
    cyc(1, 0, 8'h44, 0);
    chk("fill_full", ia.full, 1);
    chk("fill_count", ia.count, 4);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk("drain_dout", ia.dout, 8'h11 * i);
      chk("drain_valid", ia.valid, 1);
    end
    cyc(0, 1, 8'h00, 0);
    chk("under_flag", ia.underflow, 1);
    chk("under_dout", ia.dout, 8'h44);
    chk("under_valid", ia.valid, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(8'h11 * i), 0);
    cyc(1, 0, 8'h55, 0);
    chk("over_flag", ia.overflow, 1);
    chk("over_count", ia.count, 4);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk("over_data", ia.dout, 8'h11 * i);
    end
    cyc(0, 0, 8'h00, 1);
    chk("clr_ovf", ia.overflow, 0);
    cyc(1, 0, 8'hA0, 0);
    cyc(1, 0, 8'hA1, 0);
    cyc(1, 1, 8'hA2, 0);
    chk("simul_count", ia.count, 2);
    chk("simul_dout", ia.dout, 8'hA0);
    cyc(0, 1, 8'h00, 0);
    chk("simul_rd1", ia.dout, 8'hA1);
    cyc(0, 1, 8'h00, 0);
    chk("simul_rd2", ia.dout, 8'hA2);
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'h01, 0);
    chk("fwft_k_count", ib.count, 1);
    chk("fwft_k_empty", ib.empty, 1);
    chk("fwft_k_valid", ib.valid, 0);
    cyc(1, 0, 8'h02, 0);
    chk("fwft_k1_valid", ib.valid, 1);
    chk("fwft_k1_dout", ib.dout, 8'h01);
    cyc(1, 1, 8'h03, 0);
    chk("fwft_pop1", ib.dout, 8'h02);
    chk("fwft_pop1_valid", ib.valid, 1);
    cyc(0, 1, 8'h00, 0);
    chk("fwft_pop2", ib.dout, 8'h03);
    cyc(0, 1, 8'h00, 0);
    chk("fwft_end_valid", ib.valid, 0);
    chk("fwft_end_empty", ib.empty, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 8'(8'hC0 + i), 0);
      cyc(0, 1, 8'h00, 0);
    end
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'h61, 0);
    cyc(1, 0, 8'h62, 0);
    cyc(1, 0, 8'h63, 0);
    cyc(0, 0, 8'h00, 0);
    chk("flush_pre_count", ib.count, 3);
    chk("flush_pre_valid", ib.valid, 1);
    chk("flush_pre_afull", ib.almost_full, 1);
    cyc(1, 0, 8'h77, 1);
    chk("flush_count", ib.count, 0);
    chk("flush_valid", ib.valid, 0);
    chk("flush_empty", ib.empty, 1);
    chk("flush_ovf", ib.overflow, 0);
    chk("flush_unf", ib.underflow, 0);
    for (int i = 0; i < 1500; i++) begin
      automatic int ph = (i / 100) % 3;
      cyc(($urandom % 4) < (ph == 0 ? 3 : ph == 1 ? 1 : 2),
          ($urandom % 4) < (ph == 0 ? 1 : ph == 1 ? 3 : 2),
          8'($urandom), ($urandom % 97) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
